fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// PC increment and the number of always-zero address alignment bits.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // free to issue a request
        ST_WAIT    = 2'd1,  // request outstanding, result will be buffered
        ST_DISCARD = 2'd2   // request outstanding, result will be dropped
    } fetch_state_t;

    localparam int PC_INCR    = 4;
    localparam int ALIGN_BITS = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead instruction buffer for the fetch unit. The head entry is always
// visible on o_head_data (zero when empty). Flush wins over push and pop.
module fetch_fifo #(
    parameter int WIDTH          = 64,
    parameter int DEPTH_BITWIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int DEPTH = 1 << DEPTH_BITWIDTH;
    localparam logic [DEPTH_BITWIDTH:0]   CNT_FULL = (DEPTH_BITWIDTH+1)'(DEPTH);
    localparam logic [DEPTH_BITWIDTH:0]   CNT_ONE  = (DEPTH_BITWIDTH+1)'(1);
    localparam logic [DEPTH_BITWIDTH-1:0] PTR_ONE  = DEPTH_BITWIDTH'(1);

    logic [WIDTH-1:0]          r_mem [DEPTH];
    logic [DEPTH_BITWIDTH-1:0] r_rd_ptr;
    logic [DEPTH_BITWIDTH-1:0] r_wr_ptr;
    logic [DEPTH_BITWIDTH:0]   r_count;
    logic                      w_do_push;
    logic                      w_do_pop;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);

    // A pop frees the head slot on the same edge, so a push into a full
    // buffer is safe when it coincides with a pop.
    assign w_do_pop  = i_pop  && !i_flush && !o_empty;
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

    assign o_head_data = o_empty ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_ONE;
            else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_ONE;
        end
    end

    // Storage array holds data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word request at a time to the
// instruction cache, buffers returned words with their PC in fetch_fifo and
// restarts at a new address on redirect.
// Optional build macro FETCH_STATS_EN adds internal 64-bit counters
// stat_fetched and stat_stall_cycles.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDRESS_BITWIDTH    = 32,
    parameter int DATA_BITWIDTH       = 32,
    parameter int FIFO_DEPTH_BITWIDTH = 2,
    parameter logic [ADDRESS_BITWIDTH-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        ic_enable,
    output logic [ADDRESS_BITWIDTH-1:0] ic_address,
    input  logic [DATA_BITWIDTH-1:0]    ic_data,
    input  logic                        ic_data_ready,
    input  logic                        ic_busy,
    output logic [DATA_BITWIDTH-1:0]    instr,
    output logic [ADDRESS_BITWIDTH-1:0] instr_pc,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    input  logic                        redirect,
    input  logic [ADDRESS_BITWIDTH-1:0] redirect_pc
);

    localparam int ENTRY_W = DATA_BITWIDTH + ADDRESS_BITWIDTH;
    localparam logic [ADDRESS_BITWIDTH-1:0] ALIGN_MASK =
        ~ADDRESS_BITWIDTH'((1 << ALIGN_BITS) - 1);
    localparam logic [ADDRESS_BITWIDTH-1:0] PC_STEP = ADDRESS_BITWIDTH'(PC_INCR);

    fetch_state_t                r_state;
    fetch_state_t                w_next_state;
    logic [ADDRESS_BITWIDTH-1:0] r_pc;
    logic                        r_run;
    logic                        w_capture;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_full;
    logic                        w_empty;
    logic [ENTRY_W-1:0]          w_head;

    // The unit only starts issuing one clock after reset release, which keeps
    // ic_enable low during reset even though the FSM sits in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_run <= 1'b0;
        else        r_run <= 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next state, cache request strobe and capture decision. ic_data_ready is
    // only looked at outside IDLE, so a stale ready during the request cycle
    // is never taken as data.
    always_comb begin
        w_next_state = r_state;
        ic_enable    = 1'b0;
        ic_address   = '0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_run && !ic_busy && !w_full && !redirect) begin
                    ic_enable    = 1'b1;
                    ic_address   = r_pc & ALIGN_MASK;
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ic_data_ready && !ic_busy) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (redirect) begin
                    w_next_state = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                // Completion of the dropped request ends the discard even if a
                // further redirect arrives in the same cycle.
                if (ic_data_ready && !ic_busy) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Redirect overrides any same-cycle push or pop.
    assign w_push = w_capture && !redirect;
    assign w_pop  = instr_ready && !w_empty && !redirect;

    // Fetch PC: jumps on redirect, advances one word per buffered instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_pc <= RESET_PC & ALIGN_MASK;
        else if (redirect) r_pc <= redirect_pc & ALIGN_MASK;
        else if (w_push)   r_pc <= r_pc + PC_STEP;
    end

    fetch_fifo #(
        .WIDTH          (ENTRY_W),
        .DEPTH_BITWIDTH (FIFO_DEPTH_BITWIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data ({ic_data, r_pc}),
        .i_pop       (w_pop),
        .i_flush     (redirect),
        .o_head_data (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign instr       = w_head[ENTRY_W-1:ADDRESS_BITWIDTH];
    assign instr_pc    = w_head[ADDRESS_BITWIDTH-1:0];
    assign instr_valid = !w_empty;

`ifdef FETCH_STATS_EN
    logic [63:0] stat_fetched;
    logic [63:0] stat_stall_cycles;

    // Count buffered instructions and cycles spent waiting on a cache miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetched      <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (w_push) stat_fetched <= stat_fetched + 64'd1;
            if ((r_state == ST_WAIT || r_state == ST_DISCARD) && ic_busy)
                stat_stall_cycles <= stat_stall_cycles + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural cache drives the DUT,
// a transaction-level model predicts requests and buffered instructions,
// and a monitor compares the buffer head against the expected queue.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ic_enable;
    logic [31:0] ic_address;
    logic [31:0] ic_data = '0;
    logic        ic_data_ready = 1'b0;
    logic        ic_busy = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDRESS_BITWIDTH    (32),
        .DATA_BITWIDTH       (32),
        .FIFO_DEPTH_BITWIDTH (2),
        .RESET_PC            (RPC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ic_enable     (ic_enable),
        .ic_address    (ic_address),
        .ic_data       (ic_data),
        .ic_data_ready (ic_data_ready),
        .ic_busy       (ic_busy),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc)
    );

    // scoreboard
    logic [31:0] exp_data_q[$];
    logic [31:0] exp_pc_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int cyc = 0;
    int occ_pre = 0;
    int first_valid_cyc = -1;

    // cache / reference model state
    bit          pend = 1'b0;
    bit          disc = 1'b0;
    int          left = 0;
    logic [31:0] pend_data = '0;
    logic [31:0] mpc = RPC;
    int          n_en = 0;
    int          first_en_cyc = -1;
    logic [31:0] last_en_addr = '0;
    logic [31:0] en_log[8];

    // stimulus knobs
    int k_rdy_pct = 100;
    int k_miss_pct = 0;
    int k_miss_min = 1;
    int k_miss_max = 1;
    int k_redir_pct = 0;
    int k_budget = -1;
    bit k_pop_on_resp = 1'b0;
    bit k_force_pop = 1'b0;
    bit k_force_redir = 1'b0;
    logic [31:0] k_redir_pc = '0;
    int idle_busy_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare the visible buffer head with the oldest expected entry.
    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            occ_pre = exp_pc_q.size();
            check("instr_valid", 32'(instr_valid), 32'(occ_pre != 0));
            if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (instr_valid && occ_pre != 0) begin
                check("instr", instr, exp_data_q[0]);
                check("instr_pc", instr_pc, exp_pc_q[0]);
                if (instr_ready && !redirect) begin
                    void'(exp_data_q.pop_front());
                    void'(exp_pc_q.pop_front());
                end
            end
        end
    end

    // One clock of cache behaviour, consumer behaviour and model update.
    task automatic step();
        bit resp;
        bit pend0;
        bit exp_en;
        bit miss;
        @(negedge clk);
        cyc++;
        pend0 = pend;
        resp  = pend && (left == 0);
        if (resp) begin
            ic_busy = 1'b0; ic_data_ready = 1'b1; ic_data = pend_data;
        end else if (pend) begin
            ic_busy = 1'b1; ic_data_ready = 1'($urandom_range(0, 1)); ic_data = $urandom;
        end else begin
            ic_busy = (idle_busy_left > 0) || (k_budget == 0);
            ic_data_ready = 1'($urandom_range(0, 1));
            ic_data = $urandom;
            if (idle_busy_left > 0) idle_busy_left--;
        end
        if (k_force_redir) begin
            redirect = 1'b1; redirect_pc = k_redir_pc; k_force_redir = 1'b0;
        end else if ($urandom_range(0, 99) < k_redir_pct) begin
            redirect = 1'b1;
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else                           redirect_pc = $urandom;
        end else begin
            redirect = 1'b0; redirect_pc = $urandom;
        end
        if (k_force_pop) begin
            instr_ready = 1'b1; k_force_pop = 1'b0;
        end else if (k_pop_on_resp) begin
            instr_ready = resp;
        end else begin
            instr_ready = ($urandom_range(0, 99) < k_rdy_pct);
        end
        #2;
        if (resp) begin
            pend = 1'b0;
            if (!redirect && !disc) begin
                exp_data_q.push_back(pend_data);
                exp_pc_q.push_back(mpc - 32'd4 + 32'd0 == mpc ? mpc : last_en_addr);
            end
            disc = 1'b0;
        end else if (pend) begin
            left--;
        end
        if (redirect) begin
            exp_data_q.delete();
            exp_pc_q.delete();
            mpc = redirect_pc & ~32'd3;
            if (pend) disc = 1'b1;
        end
        exp_en = !pend0 && !redirect && !ic_busy && (occ_pre < 4);
        check("ic_enable", 32'(ic_enable), 32'(exp_en));
        if (ic_enable) begin
            check("ic_address", ic_address, mpc);
            if (n_en < 8) en_log[n_en] = ic_address;
            if (n_en == 0) first_en_cyc = cyc;
            n_en++;
            last_en_addr = mpc;
            pend = 1'b1;
            pend_data = $urandom;
            miss = ($urandom_range(0, 99) < k_miss_pct);
            left = miss ? $urandom_range(k_miss_min, k_miss_max) : 0;
            mpc = mpc + 32'd4;
            if (k_budget > 0) k_budget--;
        end
    endtask

    task automatic do_reset(input bit busy_during, input int busy_after);
        @(negedge clk);
        chk_en = 1'b0;
        rst_n = 1'b0;
        redirect = 1'b0;
        instr_ready = 1'b0;
        ic_busy = busy_during;
        ic_data_ready = busy_during;
        #1;
        check("rst ic_enable", 32'(ic_enable), 32'd0);
        check("rst ic_address", ic_address, 32'd0);
        check("rst instr", instr, 32'd0);
        check("rst instr_pc", instr_pc, 32'd0);
        check("rst instr_valid", 32'(instr_valid), 32'd0);
        pend = 1'b0; disc = 1'b0; left = 0; mpc = RPC;
        exp_data_q.delete(); exp_pc_q.delete();
        occ_pre = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        idle_busy_left = busy_after;
    endtask

    task automatic clear_log();
        n_en = 0; first_en_cyc = -1; first_valid_cyc = -1;
        for (int i = 0; i < 8; i++) en_log[i] = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int cyc0;

        // Always-hit cache, consumer always ready: sequential fetch from RESET_PC.
        do_reset(1'b0, 0);
        clear_log();
        repeat (10) step();
        check("seq addr0", en_log[0], 32'h100);
        check("seq addr1", en_log[1], 32'h104);
        check("seq addr2", en_log[2], 32'h108);
        check("hit latency", 32'(first_valid_cyc - first_en_cyc), 32'd2);
        check("hit throughput", 32'(n_en), 32'd5);

        // Consumer stalled: buffer fills after exactly four requests.
        do_reset(1'b0, 0);
        k_rdy_pct = 0;
        clear_log();
        repeat (20) step();
        check("full req count", 32'(n_en), 32'd4);
        clear_log();
        k_force_pop = 1'b1;
        step();
        repeat (20) step();
        check("one pop one req", 32'(n_en), 32'd1);

        // Long miss at 0x200, then redirect while the 0x20C miss is outstanding.
        do_reset(1'b0, 0);
        k_rdy_pct = 0; k_miss_pct = 100; k_miss_min = 10; k_miss_max = 10;
        k_force_redir = 1'b1; k_redir_pc = 32'h200;
        clear_log();
        g = 0;
        while (first_valid_cyc < 0 && g < 200) begin step(); g++; end
        check("miss done", 32'(first_valid_cyc >= 0), 32'd1);
        check("miss addr", en_log[0], 32'h200);
        check("miss latency", 32'(first_valid_cyc - first_en_cyc), 32'd12);
        check("miss instr_pc", instr_pc, 32'h200);
        g = 0;
        while (n_en < 4 && g < 300) begin step(); g++; end
        check("0x20C issued", last_en_addr, 32'h20C);
        repeat (3) step();
        k_force_redir = 1'b1; k_redir_pc = 32'h402;
        step();
        @(posedge clk); #1;
        check("flush valid", 32'(instr_valid), 32'd0);
        k_miss_pct = 0;
        clear_log();
        repeat (30) step();
        check("redirect addr", en_log[0], 32'h400);
        check("refill count", 32'(n_en), 32'd4);

        // Two entries held while every push coincides with a pop.
        do_reset(1'b0, 0);
        k_rdy_pct = 0; k_budget = 2;
        repeat (10) step();
        k_budget = 8; k_pop_on_resp = 1'b1;
        repeat (24) step();
        k_pop_on_resp = 1'b0; k_budget = -1;
        clear_log();
        repeat (20) step();
        check("occupancy kept 2", 32'(n_en), 32'd2);

        // Reset in the middle of a miss with the cache still busy afterwards.
        do_reset(1'b0, 0);
        k_rdy_pct = 100; k_miss_pct = 100; k_miss_min = 10; k_miss_max = 10;
        clear_log();
        g = 0;
        while (n_en < 1 && g < 20) begin step(); g++; end
        repeat (3) step();
        do_reset(1'b1, 4);
        k_miss_pct = 0;
        clear_log();
        cyc0 = cyc;
        repeat (12) step();
        check("post-rst addr", en_log[0], RPC);
        check("post-rst wait busy", 32'(first_en_cyc - cyc0), 32'd5);

        // Randomized traffic: misses, stalls, redirects (incl. wrap at top).
        do_reset(1'b0, 0);
        for (int blk = 0; blk < 30; blk++) begin
            k_rdy_pct   = $urandom_range(0, 100);
            k_miss_pct  = $urandom_range(0, 40);
            k_miss_min  = 1;
            k_miss_max  = $urandom_range(1, 8);
            k_redir_pct = $urandom_range(0, 8);
            idle_busy_left = $urandom_range(0, 3);
            repeat (100) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
